pb_switch_input_port: RTL and testbench

PicoBlaze (KCPSM3) input-side peripheral: synchronises and debounces the board slide switches and captures rising edges. It presents data, edge and mask registers on `in_port` through the processor's `port_id`/`read_strobe` bus, and raises `interrupt` with an `interrupt_ack` handshake. It sits beside the 7-segment/LED output latch on the same embedded processor and replaces the raw `sw`-to-`in_port` connection.

---
 rtl/pb_io_pkg.sv | 20 ++
 rtl/switch_debounce.sv | 52 +++++
 rtl/pb_switch_input_port.sv | 122 ++++++++++++
 tb/tb_pb_switch_input_port.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pb_io_pkg
// Brief    : Shared port addresses and interrupt state type for PicoBlaze I/O.
// Revision : 1.0
// ============================================================================
package pb_io_pkg;

    localparam logic [7:0] c_addr_data = 8'h00;
    localparam logic [7:0] c_addr_edge = 8'h01;
    localparam logic [7:0] c_addr_mask = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_PEND     = 2'b01,
        ST_WAIT_CLR = 2'b10
    } irq_state_t;

endpackage
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
// Module   : switch_debounce
// Brief    : One-bit 2-flop synchroniser plus stable-level debounce counter.
// Revision : 1.0
// ============================================================================
module switch_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic CLK1,
    input  logic arst_n,
    input  logic sw,
    output logic stable,
    output logic rise
);

    localparam int              c_cw   = $clog2(DEB_CYCLES);
    localparam logic [c_cw-1:0] c_last = c_cw'(DEB_CYCLES - 1);

    logic            r_meta;
    logic            r_sync;
    logic            r_stable;
    logic [c_cw-1:0] r_cnt;
    logic            w_accept;

    // Accept on the cycle the counter has already seen DEB_CYCLES-1 differing samples.
    assign w_accept = (r_sync != r_stable) && (r_cnt == c_last);
    assign rise     = w_accept && r_sync;
    assign stable   = r_stable;

    always_ff @(posedge CLK1 or negedge arst_n) begin
        if (!arst_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_meta <= sw;
            r_sync <= r_meta;
            if (r_sync == r_stable) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pb_switch_input_port.sv
`default_nettype none
// ============================================================================
// Module   : pb_switch_input_port
// Brief    : Debounced switch input port with edge capture, mask and interrupt.
// Revision : 1.0
// ============================================================================
module pb_switch_input_port
    import pb_io_pkg::*;
#(
    parameter int         N          = 8,
    parameter int         DEB_CYCLES = 50000,
    parameter logic [7:0] ADDR_DATA  = c_addr_data,
    parameter logic [7:0] ADDR_EDGE  = c_addr_edge,
    parameter logic [7:0] ADDR_MASK  = c_addr_mask
) (
    input  logic         CLK1,
    input  logic         arst_n,
    input  logic [N-1:0] sw,
    input  logic [7:0]   port_id,
    input  logic         read_strobe,
    input  logic         write_strobe,
    input  logic [7:0]   out_port,
    output logic [7:0]   in_port,
    output logic         interrupt,
    input  logic         interrupt_ack
);

    logic [7:0] w_stable;
    logic [7:0] w_rise;
    logic [7:0] w_edge_clr;
    logic [7:0] w_rd_data;
    logic       w_req;

    logic [7:0] r_edge;
    logic [7:0] r_mask;
    logic [7:0] r_in_port;
    logic       r_interrupt;
    irq_state_t r_state;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        if (i < N) begin : g_sw
            switch_debounce #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_deb (
                .CLK1   (CLK1),
                .arst_n (arst_n),
                .sw     (sw[i]),
                .stable (w_stable[i]),
                .rise   (w_rise[i])
            );
        end else begin : g_pad
            assign w_stable[i] = 1'b0;
            assign w_rise[i]   = 1'b0;
        end
    end

    // Only the bits the processor actually received are cleared.
    assign w_edge_clr = (read_strobe && (port_id == ADDR_EDGE)) ? r_in_port : 8'h00;
    assign w_req      = |(r_edge & r_mask);

    always_comb begin
        w_rd_data = 8'h00;
        if (port_id == ADDR_DATA) begin
            w_rd_data = w_stable;
        end else if (port_id == ADDR_EDGE) begin
            w_rd_data = r_edge;
        end else if (port_id == ADDR_MASK) begin
            w_rd_data = r_mask;
        end
    end

    always_ff @(posedge CLK1 or negedge arst_n) begin
        if (!arst_n) begin
            r_edge    <= 8'h00;
            r_mask    <= 8'h00;
            r_in_port <= 8'h00;
        end else begin
            r_edge    <= (r_edge & ~w_edge_clr) | w_rise;
            r_in_port <= w_rd_data;
            if (write_strobe && (port_id == ADDR_MASK)) begin
                r_mask <= out_port;
            end
        end
    end

    // WAIT_CLR holds off a fresh request until the serviced edge has been read away.
    always_ff @(posedge CLK1 or negedge arst_n) begin
        if (!arst_n) begin
            r_state     <= ST_IDLE;
            r_interrupt <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_state     <= ST_PEND;
                        r_interrupt <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (interrupt_ack) begin
                        r_state     <= ST_WAIT_CLR;
                        r_interrupt <= 1'b0;
                    end
                end
                ST_WAIT_CLR: begin
                    if (!w_req) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_interrupt <= 1'b0;
                end
            endcase
        end
    end

    assign in_port   = r_in_port;
    assign interrupt = r_interrupt;

endmodule
`default_nettype wire

// File: tb/tb_pb_switch_input_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_pb_switch_input_port
// Brief    : Directed bench for pb_switch_input_port with a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_pb_switch_input_port;

    localparam int         c_n      = 8;
    localparam int         c_deb    = 4;
    localparam logic [7:0] c_a_data = 8'h00;
    localparam logic [7:0] c_a_edge = 8'h01;
    localparam logic [7:0] c_a_mask = 8'h02;
    localparam logic [7:0] c_a_idle = 8'h10;

    logic           CLK1 = 1'b0;
    logic           arst_n;
    logic [c_n-1:0] sw;
    logic [7:0]     port_id;
    logic           read_strobe;
    logic           write_strobe;
    logic [7:0]     out_port;
    logic [7:0]     in_port;
    logic           interrupt;
    logic           interrupt_ack;

    int vectors     = 0;
    int miscompares = 0;
    bit running     = 1'b0;

    pb_switch_input_port #(
        .N          (c_n),
        .DEB_CYCLES (c_deb),
        .ADDR_DATA  (c_a_data),
        .ADDR_EDGE  (c_a_edge),
        .ADDR_MASK  (c_a_mask)
    ) dut (
        .CLK1          (CLK1),
        .arst_n        (arst_n),
        .sw            (sw),
        .port_id       (port_id),
        .read_strobe   (read_strobe),
        .write_strobe  (write_strobe),
        .out_port      (out_port),
        .in_port       (in_port),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack)
    );

    always #5 CLK1 = ~CLK1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 8'h%02h, expected 8'h%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a switch level is accepted once the last c_deb synchronised samples agree.
    logic [7:0] m_stable  = 8'h00;
    logic [7:0] m_edge    = 8'h00;
    logic [7:0] m_mask    = 8'h00;
    logic [7:0] m_in      = 8'h00;
    logic       m_irq     = 1'b0;
    logic       m_blocked = 1'b0;
    logic [7:0] m_hist [0:c_deb];
    logic [7:0] m_ns, m_rise, m_clr, m_nxt_in;
    logic       m_req, m_same;

    always @(posedge CLK1 or negedge arst_n) begin
        if (!arst_n) begin
            m_stable  = 8'h00;
            m_edge    = 8'h00;
            m_mask    = 8'h00;
            m_in      = 8'h00;
            m_irq     = 1'b0;
            m_blocked = 1'b0;
            for (int k = 0; k <= c_deb; k++) m_hist[k] = 8'h00;
        end else begin
            // m_hist[1] is the sample now leaving the synchroniser.
            m_ns = m_stable;
            for (int b = 0; b < 8; b++) begin
                m_same = 1'b1;
                for (int k = 2; k <= c_deb; k++)
                    if (m_hist[k][b] != m_hist[1][b]) m_same = 1'b0;
                if (m_same && (m_hist[1][b] != m_stable[b])) m_ns[b] = m_hist[1][b];
            end
            m_rise = m_ns & ~m_stable;
            m_clr  = (read_strobe && port_id == c_a_edge) ? m_in : 8'h00;
            m_req  = |(m_edge & m_mask);
            case (port_id)
                c_a_data: m_nxt_in = m_stable;
                c_a_edge: m_nxt_in = m_edge;
                c_a_mask: m_nxt_in = m_mask;
                default:  m_nxt_in = 8'h00;
            endcase
            if (m_irq) begin
                if (interrupt_ack) begin
                    m_irq     = 1'b0;
                    m_blocked = 1'b1;
                end
            end else if (m_blocked) begin
                if (!m_req) m_blocked = 1'b0;
            end else if (m_req) begin
                m_irq = 1'b1;
            end
            m_edge = (m_edge & ~m_clr) | m_rise;
            if (write_strobe && port_id == c_a_mask) m_mask = out_port;
            m_stable = m_ns;
            m_in     = m_nxt_in;
            for (int k = c_deb; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = sw;
        end
    end

    always @(negedge CLK1) begin
        if (running) begin
            check("in_port_model", in_port, m_in);
            check("interrupt_model", {7'b0, interrupt}, {7'b0, m_irq});
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge CLK1);
            #1;
        end
    endtask

    task automatic read_port(input logic [7:0] addr, input string name, input logic [7:0] exp);
        port_id = addr;
        cyc(1);
        read_strobe = 1'b1;
        check(name, in_port, exp);
        cyc(1);
        read_strobe = 1'b0;
        port_id     = c_a_idle;
    endtask

    task automatic write_port(input logic [7:0] addr, input logic [7:0] data);
        port_id      = addr;
        out_port     = data;
        write_strobe = 1'b1;
        cyc(1);
        write_strobe = 1'b0;
        port_id      = c_a_idle;
    endtask

    task automatic ack_pulse();
        interrupt_ack = 1'b1;
        cyc(1);
        interrupt_ack = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        arst_n        = 1'b0;
        sw            = 8'hFF;
        port_id       = c_a_data;
        read_strobe   = 1'b0;
        write_strobe  = 1'b0;
        out_port      = 8'h00;
        interrupt_ack = 1'b0;
        running       = 1'b1;

        // Reset, then re-assert in the middle of a debounce count.
        cyc(2);
        check("reset_in_port", in_port, 8'h00);
        check("reset_irq", {7'b0, interrupt}, 8'h00);
        arst_n = 1'b1;
        cyc(3);
        arst_n = 1'b0;
        cyc(2);
        check("midreset_in_port", in_port, 8'h00);
        arst_n = 1'b1;
        cyc(6);
        check("data_before_accept", in_port, 8'h00);
        cyc(1);
        check("data_after_reset", in_port, 8'hFF);
        read_port(c_a_edge, "edge_after_reset", 8'hFF);
        read_port(c_a_edge, "edge_reread", 8'h00);

        // Falling edges ignored; glitch rejection; exact hold latency.
        sw = 8'h00;
        cyc(8);
        read_port(c_a_edge, "edge_fall_ignored", 8'h00);
        sw = 8'h01;
        cyc(3);
        sw = 8'h00;
        cyc(8);
        read_port(c_a_data, "glitch_rejected", 8'h00);
        port_id = c_a_data;
        sw      = 8'h01;
        cyc(6);
        check("hold_pre", in_port, 8'h00);
        cyc(1);
        check("hold_data", in_port, 8'h01);
        read_port(c_a_edge, "edge_bit0", 8'h01);

        // Clear-on-read.
        sw = 8'h05;
        cyc(8);
        read_port(c_a_edge, "edge_bit2", 8'h04);
        read_port(c_a_edge, "edge_bit2_cleared", 8'h00);
        sw = 8'h01;
        cyc(8);
        read_port(c_a_edge, "edge_bit2_fall", 8'h00);

        // Interrupt handshake.
        write_port(c_a_mask, 8'h01);
        sw = 8'h00;
        cyc(8);
        check("irq_idle", {7'b0, interrupt}, 8'h00);
        sw = 8'h01;
        cyc(6);
        check("irq_pre", {7'b0, interrupt}, 8'h00);
        cyc(1);
        check("irq_rise", {7'b0, interrupt}, 8'h01);
        ack_pulse();
        check("irq_ack_fall", {7'b0, interrupt}, 8'h00);
        cyc(4);
        check("irq_held_low", {7'b0, interrupt}, 8'h00);
        read_port(c_a_edge, "irq_edge", 8'h01);
        cyc(2);
        check("irq_after_clear", {7'b0, interrupt}, 8'h00);
        sw = 8'h00;
        cyc(8);
        sw = 8'h01;
        cyc(7);
        check("irq_reassert", {7'b0, interrupt}, 8'h01);
        ack_pulse();
        read_port(c_a_edge, "irq_edge2", 8'h01);
        cyc(2);
        interrupt_ack = 1'b1;
        cyc(2);
        interrupt_ack = 1'b0;

        // Masking.
        write_port(c_a_mask, 8'h00);
        sw = 8'h81;
        cyc(8);
        check("mask_blocks", {7'b0, interrupt}, 8'h00);
        write_port(c_a_mask, 8'h80);
        check("mask_pre", {7'b0, interrupt}, 8'h00);
        cyc(1);
        check("mask_irq", {7'b0, interrupt}, 8'h01);
        ack_pulse();
        read_port(c_a_edge, "mask_edge", 8'h80);
        read_port(c_a_mask, "mask_read", 8'h80);

        // Mask write and mask read in the same cycle return the old value.
        port_id      = c_a_mask;
        out_port     = 8'h3C;
        write_strobe = 1'b1;
        cyc(1);
        write_strobe = 1'b0;
        check("mask_old", in_port, 8'h80);
        cyc(1);
        check("mask_new", in_port, 8'h3C);
        write_port(c_a_mask, 8'h00);

        // New edge landing on the clear strobe survives.
        sw = 8'h83;
        cyc(4);
        read_port(c_a_edge, "collide_first", 8'h00);
        read_port(c_a_edge, "collide_keep", 8'h02);
        read_port(c_a_data, "final_data", 8'h83);

        cyc(2);
        running = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
